onehot_rr_arbiter: RTL

ONEHOT_RR_ARBITER -- requirements
Module: onehot_rr_arbiter

---
 rtl/onehot_rr_arbiter_pkg.sv | 6 +
 rtl/onehot_rr_arbiter_rr_priority_pick.sv | 27 ++
 rtl/onehot_rr_arbiter.sv | 53 +++++
 3 files changed

// File: rtl/onehot_rr_arbiter_pkg.sv
// onehot_rr_arbiter_pkg: shared sizes and FSM encoding for the one-hot round-robin arbiter
package onehot_rr_arbiter_pkg;
  localparam int N_DEF = 16;
  localparam int PTR_W = 4;
  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;
endpackage

// File: rtl/onehot_rr_arbiter_rr_priority_pick.sv
// rr_priority_pick: lowest set bit of pending at or above ptr, wrapping N-1 -> 0
module rr_priority_pick
  import onehot_rr_arbiter_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0]     pending,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     pick,
  output logic [PTR_W-1:0] pick_idx
);
  logic found;
  always_comb begin
    pick = '0;
    pick_idx = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (int'(ptr) + i) % N;
      if (!found && pending[k]) begin
        found = 1'b1;
        pick[k] = 1'b1;
        pick_idx = PTR_W'(k);
      end
    end
  end
endmodule

// File: rtl/onehot_rr_arbiter.sv
// onehot_rr_arbiter: captures request pulses and offers one registered one-hot grant at a time
module onehot_rr_arbiter
  import onehot_rr_arbiter_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic [N-1:0] grant_onehot,
  output logic         grant_valid,
  output logic [N-1:0] pending,
  output logic         overflow
);
  state_t state, state_nx;
  logic [N-1:0] pick, clr;
  logic [PTR_W-1:0] ptr, pick_idx, gidx, ptr_inc;
  rr_priority_pick #(.N(N)) u_pick (
    .pending (pending),
    .ptr     (ptr),
    .pick    (pick),
    .pick_idx(pick_idx)
  );
  assign grant_valid = (state == OFFER);
  assign clr = (grant_valid && out_ready) ? grant_onehot : '0;
  assign ptr_inc = (gidx == PTR_W'(N - 1)) ? '0 : gidx + 1'b1;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? ((|pending) ? OFFER : IDLE) : (out_ready ? IDLE : OFFER);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= '0;
      overflow <= 1'b0;
      grant_onehot <= '0;
      gidx <= '0;
      ptr <= '0;
    end else begin
      state <= state_nx;
      pending <= (pending & ~clr) | req;
      overflow <= |(req & pending & ~clr);
      if (state == IDLE && |pending) begin
        grant_onehot <= pick;
        gidx <= pick_idx;
      end else if (state == OFFER && out_ready) begin
        grant_onehot <= '0;
        ptr <= ptr_inc;
      end
    end
  end
endmodule
